// File: rtl/serial_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encoding,
// gap counter width and default pattern length.
package serial_gen_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int GAP_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_gen_shifter.sv
// PISO shifter: loads a right-aligned pattern MSB-first, shifts one bit per clk.
// Latency: o_bit shows the first bit the cycle after i_load; no stalls.
// Backpressure: none; the caller decides when to load and shift.
module serial_gen_shifter
    import serial_gen_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [MAX_LEN-1:0] i_data,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_bit,
    output logic               o_last,
    output logic               o_next_last
);

    logic [MAX_LEN-1:0] r_sh;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_shamt;

    assign w_shamt = LEN_W'(MAX_LEN) - i_len;

    // Zero fill keeps o_bit low once the pattern has drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_data << w_shamt;
            r_cnt <= i_len - 1'b1;
        end else if (i_shift) begin
            r_sh  <= r_sh << 1;
            r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        end
    end

    assign o_bit       = r_sh[MAX_LEN-1];
    assign o_last      = (r_cnt == '0);
    assign o_next_last = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter, MSB-first, optional repeats via SERIAL_PATTERN_GEN_REPEAT_EN.
// Latency: first bit one cycle after accept; GAP_CYCLES idle bits between patterns.
// Backpressure: pat_ready only while idle; held pat_valid is taken on the first idle cycle.
module serial_pattern_gen
    import serial_gen_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_W      = $clog2(MAX_LEN + 1),
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               pat_valid,
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    input  logic [3:0]         pat_rep,
`endif
    output logic               pat_ready,
    output logic               out,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES);

    state_t               r_state, w_next_state;
    logic [MAX_LEN-1:0]   r_pat, w_load_data;
    logic [LEN_W-1:0]     r_len, w_len, w_load_len;
    logic [3:0]           r_rep, w_next_rep, w_rep_in, w_rep_dec;
    logic [GAP_CNT_W-1:0] r_gap;
    logic                 r_out_valid, r_pat_ready, r_busy, r_done;
    logic                 w_accept, w_load;
    logic                 w_bit, w_last, w_next_last;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    assign w_rep_in = pat_rep;
`else
    assign w_rep_in = 4'd0;
`endif

    assign w_len     = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
    assign w_accept  = pat_valid && r_pat_ready;
    assign w_rep_dec = r_rep - 4'd1;

    // The FSM runs one cycle ahead of the line: it leaves SHIFT as the last
    // bit is loaded, so the idle count lines up with the bits actually sent.
    function automatic state_t after_last(input logic [3:0] rep_left);
        return (GAP_CYCLES == 0 && rep_left == 4'd0) ? ST_IDLE : ST_GAP;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_data  = pat_data;
        w_load_len   = w_len;
        w_next_rep   = r_rep;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_len != '0) begin
                    w_load       = 1'b1;
                    w_next_rep   = w_rep_in;
                    w_next_state = (w_len == LEN_W'(1)) ? after_last(w_rep_in) : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_next_last) w_next_state = after_last(r_rep);
            end
            ST_GAP: begin
                if (r_rep != 4'd0) begin
                    if (r_gap == '0) begin
                        w_load       = 1'b1;
                        w_load_data  = r_pat;
                        w_load_len   = r_len;
                        w_next_rep   = w_rep_dec;
                        w_next_state = (r_len == LEN_W'(1)) ? after_last(w_rep_dec) : ST_SHIFT;
                    end
                end else if (r_gap <= GAP_CNT_W'(1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat       <= '0;
            r_len       <= '0;
            r_rep       <= '0;
            r_gap       <= '0;
            r_out_valid <= 1'b0;
            r_pat_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rep <= w_next_rep;
            if (w_load && r_state == ST_IDLE) begin
                r_pat <= pat_data;
                r_len <= w_len;
            end
            if (w_next_state == ST_GAP && (r_state != ST_GAP || w_load))
                r_gap <= GAP_LOAD;
            else if (r_state == ST_GAP && r_gap != '0)
                r_gap <= r_gap - 1'b1;
            r_out_valid <= w_load || (r_out_valid && !w_last);
            r_pat_ready <= (w_next_state == ST_IDLE);
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (r_out_valid && w_last && r_rep == 4'd0) || (w_accept && w_len == '0);
        end
    end

    serial_gen_shifter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_shift     (r_out_valid),
        .i_data      (w_load_data),
        .i_len       (w_load_len),
        .o_bit       (w_bit),
        .o_last      (w_last),
        .o_next_last (w_next_last)
    );

    assign out       = w_bit;
    assign out_valid = r_out_valid;
    assign pat_ready = r_pat_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed and random pattern streams compared
// cycle by cycle against a timeline model built from the line protocol rules.
module tb_serial_pattern_gen;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int GAP     = 1;
    localparam int HOR     = 2048;

    logic             clk = 1'b0;
    logic             rst;
    logic [MAX_LEN-1:0] pat_data;
    logic [LEN_W-1:0] pat_len;
    logic             pat_valid;
    logic             pat_ready, out, out_valid, busy, done;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    logic [3:0]       pat_rep;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] s_data [8];
    int         s_len  [8];
    int         s_rep  [8];

    always #5 clk = ~clk;

    serial_pattern_gen #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .pat_valid (pat_valid),
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
        .pat_rep   (pat_rep),
`endif
        .pat_ready (pat_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        pat_valid = 1'b0;
        pat_data  = 8'($urandom);
        pat_len   = 4'($urandom);
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
        pat_rep   = 4'($urandom);
`endif
    endtask

    // Timeline model: pattern p is accepted at acc[p]; each pass puts L bits on
    // the line starting the next cycle, passes/patterns are GAP idle cycles apart,
    // done follows the final bit, and len=0 only produces a done pulse.
    task automatic run_stream(input int n, input string name);
        int acc [8];
        bit e_ov [HOR];
        bit e_out [HOR];
        bit e_done [HOR];
        bit e_rdy [HOR];
        int t, base, L, R, idx, last;
        for (int c = 0; c < HOR; c++) begin
            e_ov[c] = 0; e_out[c] = 0; e_done[c] = 0; e_rdy[c] = 1;
        end
        t = 0;
        for (int p = 0; p < n; p++) begin
            acc[p] = t;
            L = (s_len[p] > MAX_LEN) ? MAX_LEN : s_len[p];
            R = (L == 0) ? 0 : s_rep[p];
            if (L == 0) begin
                e_done[t + 1] = 1;
                t = t + 1;
            end else begin
                base = t;
                for (int r = 0; r <= R; r++) begin
                    for (int i = 0; i < L; i++) begin
                        e_ov[base + 1 + i]  = 1;
                        e_out[base + 1 + i] = s_data[p][L - 1 - i];
                    end
                    if (r == R) e_done[base + L + 1] = 1;
                    base = base + L + GAP;
                end
                for (int c = acc[p] + 1; c < base; c++) e_rdy[c] = 0;
                t = base;
            end
        end
        last = t + GAP + 4;
        idx = 0;
        for (int c = 0; c <= last; c++) begin
            if (idx < n && c > acc[idx]) idx++;
            if (idx < n) begin
                pat_valid = 1'b1;
                pat_data  = s_data[idx];
                pat_len   = 4'(s_len[idx]);
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
                pat_rep   = 4'(s_rep[idx]);
`endif
            end else begin
                drive_idle();
            end
            check_val($sformatf("%s ov@%0d", name, c), 32'(out_valid), 32'(e_ov[c]));
            check_val($sformatf("%s out@%0d", name, c), 32'(out), 32'(e_out[c]));
            check_val($sformatf("%s done@%0d", name, c), 32'(done), 32'(e_done[c]));
            check_val($sformatf("%s rdy@%0d", name, c), 32'(pat_ready), 32'(e_rdy[c]));
            check_val($sformatf("%s busy@%0d", name, c), 32'(busy), 32'(!e_rdy[c]));
            tick();
        end
        drive_idle();
    endtask

    task automatic run_abort();
        logic [7:0] d;
        d = 8'($urandom);
        pat_valid = 1'b1;
        pat_data  = d;
        pat_len   = 4'd5;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
        pat_rep   = 4'd0;
`endif
        tick();
        drive_idle();
        check_val("abort bit1 ov", 32'(out_valid), 32'd1);
        check_val("abort bit1 out", 32'(out), 32'(d[4]));
        tick();
        check_val("abort bit2 out", 32'(out), 32'(d[3]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort ov", 32'(out_valid), 32'd0);
        check_val("abort out", 32'(out), 32'd0);
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort rdy", 32'(pat_ready), 32'd0);
        check_val("abort done", 32'(done), 32'd0);
        tick();
        check_val("abort rdy back", 32'(pat_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            check_val($sformatf("abort quiet done@%0d", c), 32'(done), 32'd0);
            check_val($sformatf("abort quiet ov@%0d", c), 32'(out_valid), 32'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        pat_valid = 1'b1;
        tick();
        tick();
        check_val("rst ov", 32'(out_valid), 32'd0);
        check_val("rst out", 32'(out), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst rdy", 32'(pat_ready), 32'd0);
        rst = 1'b0;
        drive_idle();
        tick();
        check_val("post-rst rdy", 32'(pat_ready), 32'd1);
        check_val("post-rst busy", 32'(busy), 32'd0);

        for (int p = 0; p < 8; p++) s_rep[p] = 0;

        s_data[0] = 8'b10;  s_len[0] = 2;
        run_stream(1, "len2");

        s_data[0] = 8'b111; s_len[0] = 3;
        s_data[1] = 8'b110; s_len[1] = 3;
        run_stream(2, "b2b");

        s_data[0] = 8'hFF;  s_len[0] = 0;
        run_stream(1, "len0");

        s_data[0] = 8'hA5;  s_len[0] = 12;
        run_stream(1, "clamp");

        s_data[0] = 8'h01;  s_len[0] = 1;
        s_data[1] = 8'h00;  s_len[1] = 0;
        s_data[2] = 8'hFE;  s_len[2] = 8;
        run_stream(3, "mix");

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
        s_data[0] = 8'b01;  s_len[0] = 2; s_rep[0] = 2;
        run_stream(1, "rep");
        s_rep[0] = 0;
`endif

        run_abort();

        for (int it = 0; it < 25; it++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int p = 0; p < n; p++) begin
                s_data[p] = 8'($urandom);
                s_len[p]  = $urandom_range(0, 15);
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
                s_rep[p]  = $urandom_range(0, 3);
`else
                s_rep[p]  = 0;
`endif
            end
            run_stream(n, $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
